mc_ctrl_fsm: RTL and testbench

//  Main control FSM for the multi-cycle RV32 core. Sequences one instruction at a time through

---
 rtl/mc_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multi-cycle RV32 core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select; outputs decode combinationally from the state register.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Trap fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    logic       w_timeout;
    logic       w_taken;
    logic       w_bad_branch;

    assign w_timeout    = (r_wait == WAIT_LAST) && !mem_ready;
    assign w_taken      = funct3[2] ? (alu_lt ^ funct3[0]) : (alu_zero ^ funct3[0]);
    assign w_bad_branch = (funct3[2:1] == 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wait  <= 8'd0;
        end else begin
            // Non-memory states have mem_req=0, so entering any memory state starts from zero.
            if (mem_req && !mem_ready)
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= 8'd0;

            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)
                        r_state <= S_DECODE;
                    else if (w_timeout)
                        r_state <= S_TRAP;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_R:              r_state <= S_EXEC_R;
                        OP_I:              r_state <= S_EXEC_I;
                        OP_LOAD, OP_STORE: r_state <= S_MEM_ADDR;
                        OP_BRANCH:         r_state <= S_BRANCH;
                        OP_JAL:            r_state <= S_JAL;
                        OP_LUI:            r_state <= S_LUI;
                        default:           r_state <= S_TRAP;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: r_state <= S_ALU_WB;
                S_ALU_WB, S_MEM_WB, S_JAL, S_LUI: r_state <= S_FETCH;
                S_MEM_ADDR: r_state <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_ready)
                        r_state <= S_MEM_WB;
                    else if (w_timeout)
                        r_state <= S_TRAP;
                end
                S_MEM_WR: begin
                    if (mem_ready)
                        r_state <= S_FETCH;
                    else if (w_timeout)
                        r_state <= S_TRAP;
                end
                S_BRANCH: r_state <= w_bad_branch ? S_TRAP : S_FETCH;
                default:  r_state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ir_write  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        illegal   = 1'b0;
        state_o   = r_state;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd2;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = 2'd2;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd1;
                pc_src    = 1'b1;
                pc_write  = w_taken && !w_bad_branch;
            end
            S_JAL: begin
                pc_src    = 1'b1;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'd2;
            end
            // LUI writes the immediate straight through the dedicated wb_sel=3 path.
            S_LUI: begin
                reg_write = 1'b1;
                wb_sel    = 2'd3;
            end
            S_TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected output vectors are queued with the
// stimulus and compared as the FSM steps through each instruction class.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       alu_zero = 1'b0;
    logic       alu_lt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_src, ir_write, mem_req, mem_we, iord, reg_write, illegal;
    logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state_o;

    int vectors = 0;
    int miscompares = 0;

    logic [19:0] exp_q[$];
    logic [32:0] stim_q[$];
    logic [19:0] obs;
    logic [19:0] e;

    mc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req),
        .mem_we(mem_we), .iord(iord), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, pc_write, pc_src, ir_write, mem_req, mem_we, iord, reg_write,
                  wb_sel, alu_src_a, alu_src_b, alu_op, illegal};

    // Expected-vector builder: field order matches obs.
    function automatic logic [19:0] mk(input logic [3:0] st, input logic pw, input logic ps,
                                       input logic iw, input logic mr, input logic we,
                                       input logic io, input logic rw, input logic [1:0] wb,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic il);
        return {st, pw, ps, iw, mr, we, io, rw, wb, a, b, op, il};
    endfunction

    function automatic logic [19:0] e_idle();          return mk(0, 0,0,0,0,0,0,0, 0,0,0,0, 0); endfunction
    function automatic logic [19:0] e_fetch(input logic r); return mk(1, r,0,r,1,0,0,0, 0,0,1,0, 0); endfunction
    function automatic logic [19:0] e_decode();        return mk(2, 0,0,0,0,0,0,0, 0,2,2,0, 0); endfunction
    function automatic logic [19:0] e_exec_r();        return mk(3, 0,0,0,0,0,0,0, 0,1,0,2, 0); endfunction
    function automatic logic [19:0] e_exec_i();        return mk(4, 0,0,0,0,0,0,0, 0,1,2,2, 0); endfunction
    function automatic logic [19:0] e_alu_wb();        return mk(5, 0,0,0,0,0,0,1, 0,0,0,0, 0); endfunction
    function automatic logic [19:0] e_mem_addr();      return mk(6, 0,0,0,0,0,0,0, 0,1,2,0, 0); endfunction
    function automatic logic [19:0] e_mem_rd();        return mk(7, 0,0,0,1,0,1,0, 0,0,0,0, 0); endfunction
    function automatic logic [19:0] e_mem_wb();        return mk(8, 0,0,0,0,0,0,1, 1,0,0,0, 0); endfunction
    function automatic logic [19:0] e_mem_wr();        return mk(9, 0,0,0,1,1,1,0, 0,0,0,0, 0); endfunction
    function automatic logic [19:0] e_branch(input logic t); return mk(10, t,1,0,0,0,0,0, 0,1,0,1, 0); endfunction
    function automatic logic [19:0] e_jal();           return mk(11, 1,1,0,0,0,0,1, 2,0,0,0, 0); endfunction
    function automatic logic [19:0] e_lui();           return mk(12, 0,0,0,0,0,0,1, 3,0,0,0, 0); endfunction
    function automatic logic [19:0] e_trap();          return mk(15, 0,0,0,0,0,0,0, 0,0,0,0, 1); endfunction

    task automatic push(input logic [19:0] ev, input logic rdy, input logic [31:0] instr);
        exp_q.push_back(ev);
        stim_q.push_back({rdy, instr});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
    endtask

    // Drives the next queued stimulus on the falling edge, then lets outputs settle.
    task automatic apply_next();
        logic [32:0] s;
        s = stim_q.pop_front();
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = s[32];
        opcode    = s[6:0];
        funct3    = s[14:12];
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        opcode = 7'b0110011;
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (obs !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, expected %h", obs, 20'd0);
        end
        push(e_idle(), 1'b0, 32'h0);
        push(e_fetch(1'b0), 1'b0, 32'h0);
        push(e_fetch(1'b1), 1'b1, 32'h0);
        while (exp_q.size() != 0) begin
            apply_next();
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_seq: got %h, expected %h", obs, e);
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins[2];
        ins[0] = 32'h002081B3;
        ins[1] = 32'h00108093;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            push(e_idle(), 1'b1, ins[k]);
            push(e_fetch(1'b1), 1'b1, ins[k]);
            push(e_decode(), 1'b1, ins[k]);
            push((k == 0) ? e_exec_r() : e_exec_i(), 1'b1, ins[k]);
            push(e_alu_wb(), 1'b1, ins[k]);
            push(e_fetch(1'b1), 1'b1, ins[k]);
            while (exp_q.size() != 0) begin
                apply_next();
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL alu_%0s: got %h, expected %h", (k == 0) ? "add" : "addi", obs, e);
                end
            end
        end
    endtask

    task automatic test_load_wait();
        do_reset();
        push(e_idle(), 1'b1, 32'h0000A103);
        push(e_fetch(1'b1), 1'b1, 32'h0000A103);
        push(e_decode(), 1'b1, 32'h0000A103);
        push(e_mem_addr(), 1'b1, 32'h0000A103);
        for (int w = 0; w < 3; w++) push(e_mem_rd(), 1'b0, 32'h0000A103);
        push(e_mem_rd(), 1'b1, 32'h0000A103);
        push(e_mem_wb(), 1'b1, 32'h0000A103);
        push(e_fetch(1'b1), 1'b1, 32'h0000A103);
        while (exp_q.size() != 0) begin
            apply_next();
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL lw_wait: got %h, expected %h", obs, e);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins[6];
        logic [5:0]  zero_v, lt_v, taken_v;
        ins[0] = 32'h00208463; ins[1] = 32'h00209463; ins[2] = 32'h0020C463;
        ins[3] = 32'h0020F463; ins[4] = 32'h0020D463; ins[5] = 32'h0020E463;
        // beq z=1 taken, bne z=1 not, blt lt=1 taken, bgeu lt=1 not, bge lt=0 taken, bltu lt=0 not
        zero_v  = 6'b000011;
        lt_v    = 6'b001100;
        taken_v = 6'b010101;
        for (int k = 0; k < 6; k++) begin
            do_reset();
            alu_zero = zero_v[k];
            alu_lt   = lt_v[k];
            push(e_idle(), 1'b1, ins[k]);
            push(e_fetch(1'b1), 1'b1, ins[k]);
            push(e_decode(), 1'b1, ins[k]);
            push(e_branch(taken_v[k]), 1'b1, ins[k]);
            push(e_fetch(1'b1), 1'b1, ins[k]);
            while (exp_q.size() != 0) begin
                apply_next();
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL branch_f3_%0d: got %h, expected %h", ins[k][14:12], obs, e);
                end
            end
        end
        alu_zero = 1'b0;
        alu_lt   = 1'b0;
    endtask

    task automatic test_jal_lui();
        do_reset();
        push(e_idle(), 1'b1, 32'h008000EF);
        push(e_fetch(1'b1), 1'b1, 32'h008000EF);
        push(e_decode(), 1'b1, 32'h008000EF);
        push(e_jal(), 1'b1, 32'h008000EF);
        push(e_fetch(1'b1), 1'b1, 32'h123450B7);
        push(e_decode(), 1'b1, 32'h123450B7);
        push(e_lui(), 1'b1, 32'h123450B7);
        push(e_fetch(1'b0), 1'b0, 32'h123450B7);
        while (exp_q.size() != 0) begin
            apply_next();
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL jal_lui: got %h, expected %h", obs, e);
            end
        end
    endtask

    task automatic test_trap();
        logic [31:0] ins[2];
        ins[0] = 32'h00000097;
        ins[1] = 32'h0020A463;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            push(e_idle(), 1'b1, ins[k]);
            push(e_fetch(1'b1), 1'b1, ins[k]);
            push(e_decode(), 1'b1, ins[k]);
            if (k == 1) push(e_branch(1'b0), 1'b1, ins[k]);
            for (int c = 0; c < 10; c++) push(e_trap(), 1'($urandom_range(0, 1)), ins[k]);
            while (exp_q.size() != 0) begin
                apply_next();
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL trap_%0s: got %h, expected %h", (k == 0) ? "auipc" : "branch010", obs, e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        push(e_idle(), 1'b0, 32'h002081B3);
        for (int c = 0; c < 4; c++) push(e_fetch(1'b0), 1'b0, 32'h002081B3);
        for (int c = 0; c < 3; c++) push(e_trap(), 1'b1, 32'h002081B3);
        while (exp_q.size() != 0) begin
            apply_next();
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL fetch_timeout: got %h, expected %h", obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(e_idle(), 1'b1, 32'h0);
        push(e_fetch(1'b1), 1'b1, 32'h0);
        push(e_decode(), 1'b1, 32'h002081B3);
        push(e_exec_r(), 1'b1, 32'h002081B3);
        push(e_alu_wb(), 1'b1, 32'h002081B3);
        push(e_fetch(1'b1), 1'b1, 32'h002081B3);
        push(e_decode(), 1'b1, 32'h0020A023);
        push(e_mem_addr(), 1'b1, 32'h0020A023);
        push(e_mem_wr(), 1'b0, 32'h0020A023);
        push(e_mem_wr(), 1'b0, 32'h0020A023);
        while (exp_q.size() != 0) begin
            apply_next();
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL back_to_back: got %h, expected %h", obs, e);
            end
        end
        // Asynchronous reset in the middle of the stalled store must clear outputs at once.
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_mid_store: got %h, expected %h", obs, 20'd0);
        end
        push(e_idle(), 1'b1, 32'h0020A023);
        push(e_fetch(1'b1), 1'b1, 32'h0020A023);
        while (exp_q.size() != 0) begin
            apply_next();
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_release: got %h, expected %h", obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_jal_lui();
        test_trap();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
